cluster_pwr_seq: RTL and testbench

CLUSTER_PWR_SEQ -- requirements
Module: cluster_pwr_seq

---
 rtl/soc_ctrl_pkg.sv | 29 ++
 rtl/cluster_pwr_sync.sv | 25 ++
 rtl/cluster_pwr_seq.sv | 158 +++++++++++++++
 tb/tb_cluster_pwr_seq.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/soc_ctrl_pkg.sv
// rtl/soc_ctrl_pkg.sv - shared SoC control types and cluster power sequencer defaults
package soc_ctrl_pkg;

  // Cluster power sequencer states; encodings are visible through APB readback
  typedef enum logic [3:0] {
    CLUSTER_OFF     = 4'd0,
    CLUSTER_PWR_UP  = 4'd1,
    CLUSTER_CLK_EN  = 4'd2,
    CLUSTER_ISO_REL = 4'd3,
    CLUSTER_RST_REL = 4'd4,
    CLUSTER_ON      = 4'd5,
    CLUSTER_STOP    = 4'd6,
    CLUSTER_ISO_SET = 4'd7,
    CLUSTER_CLK_DIS = 4'd8,
    CLUSTER_PWR_DN  = 4'd9,
    CLUSTER_ERROR   = 4'd15
  } cluster_pwr_state_e;

  localparam int unsigned CLUSTER_CLK_SETTLE_CYC  = 16;
  localparam int unsigned CLUSTER_RST_HOLD_CYC    = 8;
  localparam int unsigned CLUSTER_PWR_TIMEOUT_CYC = 1024;
  localparam int unsigned CLUSTER_CNT_WIDTH       = 16;

  // Resting states are the ones where software is expected to act next
  function automatic logic cluster_state_is_busy(cluster_pwr_state_e st);
    return !(st inside {CLUSTER_OFF, CLUSTER_ON, CLUSTER_ERROR});
  endfunction

endpackage

// File: rtl/cluster_pwr_sync.sv
// rtl/cluster_pwr_sync.sv - two-flop synchronizer for the power-switch good flag
module cluster_pwr_sync (
  input  logic HCLK,
  input  logic HRESET,
  input  logic level_async,
  output logic level_sync
);

  logic meta_q;
  logic sync_q;

  // Two stages give the first flop a full cycle to resolve metastability
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= level_async;
      sync_q <= meta_q;
    end
  end

  assign level_sync = sync_q;

endmodule

// File: rtl/cluster_pwr_seq.sv
// rtl/cluster_pwr_seq.sv - cluster power-up/power-down sequencer
module cluster_pwr_seq
  import soc_ctrl_pkg::*;
#(
  parameter int unsigned CLK_SETTLE_CYC  = CLUSTER_CLK_SETTLE_CYC,
  parameter int unsigned RST_HOLD_CYC    = CLUSTER_RST_HOLD_CYC,
  parameter int unsigned PWR_TIMEOUT_CYC = CLUSTER_PWR_TIMEOUT_CYC,
  parameter int unsigned CNT_WIDTH       = CLUSTER_CNT_WIDTH
) (
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic       pow_req_i,
  input  logic       byp_req_i,
  input  logic       fetch_en_req_i,
  input  logic       pwr_ok_i,
  output logic       cluster_pow_o,
  output logic       cluster_clk_en_o,
  output logic       cluster_iso_o,
  output logic       cluster_rstn_o,
  output logic       cluster_fetch_enable_o,
  output logic       cluster_byp_o,
  output logic       busy_o,
  output logic       err_o,
  output logic       evt_o,
  output logic [3:0] state_o
);

  // Last counter value of each timed state (counter is 0 in the first cycle)
  localparam logic [CNT_WIDTH-1:0] SETTLE_LAST  = CNT_WIDTH'(CLK_SETTLE_CYC - 1);
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST    = CNT_WIDTH'(RST_HOLD_CYC - 1);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(PWR_TIMEOUT_CYC - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE      = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX      = {CNT_WIDTH{1'b1}};

  cluster_pwr_state_e   state_q;
  cluster_pwr_state_e   state_d;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 pok;
  logic                 fetch_q;
  logic                 byp_q;
  logic                 evt_q;

  cluster_pwr_sync u_sync (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .level_async (pwr_ok_i),
    .level_sync  (pok)
  );

  // State register and shared dwell counter, cleared whenever the state changes
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= CLUSTER_OFF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + CNT_ONE;
      end
    end
  end

  // Request registers and the event pulse on arrival in a resting state
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      fetch_q <= 1'b0;
      byp_q   <= 1'b1;
      evt_q   <= 1'b0;
    end else begin
      fetch_q <= fetch_en_req_i;
      if (state_q == CLUSTER_OFF) begin
        byp_q <= byp_req_i;
      end
      evt_q <= (state_d != state_q) &&
               (state_d inside {CLUSTER_OFF, CLUSTER_ON, CLUSTER_ERROR});
    end
  end

  // Next-state decode and per-state rail outputs; requests only matter in OFF, ON and ERROR
  always_comb begin
    state_d          = state_q;
    cluster_pow_o    = 1'b0;
    cluster_clk_en_o = 1'b0;
    cluster_iso_o    = 1'b1;
    cluster_rstn_o   = 1'b0;
    cluster_fetch_enable_o = 1'b0;
    case (state_q)
      CLUSTER_OFF: begin
        if (pow_req_i) state_d = CLUSTER_PWR_UP;
      end
      CLUSTER_PWR_UP: begin
        cluster_pow_o = 1'b1;
        // A late pok still wins over a timeout in the same cycle
        if (pok) state_d = CLUSTER_CLK_EN;
        else if (cnt_q >= TIMEOUT_LAST) state_d = CLUSTER_ERROR;
      end
      CLUSTER_CLK_EN: begin
        cluster_pow_o    = 1'b1;
        cluster_clk_en_o = 1'b1;
        if (cnt_q >= SETTLE_LAST) state_d = CLUSTER_ISO_REL;
      end
      CLUSTER_ISO_REL: begin
        cluster_pow_o    = 1'b1;
        cluster_clk_en_o = 1'b1;
        cluster_iso_o    = 1'b0;
        state_d          = CLUSTER_RST_REL;
      end
      CLUSTER_RST_REL: begin
        cluster_pow_o    = 1'b1;
        cluster_clk_en_o = 1'b1;
        cluster_iso_o    = 1'b0;
        if (cnt_q >= HOLD_LAST) state_d = CLUSTER_ON;
      end
      CLUSTER_ON: begin
        cluster_pow_o          = 1'b1;
        cluster_clk_en_o       = 1'b1;
        cluster_iso_o          = 1'b0;
        cluster_rstn_o         = 1'b1;
        cluster_fetch_enable_o = fetch_q;
        if (!pow_req_i) state_d = CLUSTER_STOP;
      end
      CLUSTER_STOP: begin
        cluster_pow_o    = 1'b1;
        cluster_clk_en_o = 1'b1;
        cluster_iso_o    = 1'b0;
        if (cnt_q >= HOLD_LAST) state_d = CLUSTER_ISO_SET;
      end
      CLUSTER_ISO_SET: begin
        cluster_pow_o    = 1'b1;
        cluster_clk_en_o = 1'b1;
        state_d          = CLUSTER_CLK_DIS;
      end
      CLUSTER_CLK_DIS: begin
        cluster_pow_o = 1'b1;
        state_d       = CLUSTER_PWR_DN;
      end
      CLUSTER_PWR_DN: begin
        if (!pok) state_d = CLUSTER_OFF;
        else if (cnt_q >= TIMEOUT_LAST) state_d = CLUSTER_ERROR;
      end
      CLUSTER_ERROR: begin
        if (!pow_req_i) state_d = CLUSTER_OFF;
      end
      default: begin
        state_d = CLUSTER_OFF;
      end
    endcase
  end

  assign cluster_byp_o = byp_q;
  assign busy_o        = cluster_state_is_busy(state_q);
  assign err_o         = (state_q == CLUSTER_ERROR);
  assign evt_o         = evt_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_cluster_pwr_seq.sv
// tb/tb_cluster_pwr_seq.sv - self-checking bench for the cluster power sequencer
module tb_cluster_pwr_seq;

  localparam int S_OFF     = 0;
  localparam int S_PWR_UP  = 1;
  localparam int S_CLK_EN  = 2;
  localparam int S_ISO_REL = 3;
  localparam int S_RST_REL = 4;
  localparam int S_ON      = 5;
  localparam int S_STOP    = 6;
  localparam int S_ISO_SET = 7;
  localparam int S_CLK_DIS = 8;
  localparam int S_PWR_DN  = 9;
  localparam int S_ERR     = 15;

  logic       HCLK = 1'b0;
  logic       HRESET = 1'b1;
  logic       pow_req_i = 1'b0;
  logic       byp_req_i = 1'b1;
  logic       fetch_en_req_i = 1'b0;
  logic       pwr_ok_i = 1'b0;
  logic       cluster_pow_o;
  logic       cluster_clk_en_o;
  logic       cluster_iso_o;
  logic       cluster_rstn_o;
  logic       cluster_fetch_enable_o;
  logic       cluster_byp_o;
  logic       busy_o;
  logic       err_o;
  logic       evt_o;
  logic [3:0] state_o;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   prev_st = S_OFF;
  logic exp_byp = 1'b1;
  int   d;
  int   e;
  int   k;

  always #5 HCLK = ~HCLK;

  cluster_pwr_seq dut (
    .HCLK                   (HCLK),
    .HRESET                 (HRESET),
    .pow_req_i              (pow_req_i),
    .byp_req_i              (byp_req_i),
    .fetch_en_req_i         (fetch_en_req_i),
    .pwr_ok_i               (pwr_ok_i),
    .cluster_pow_o          (cluster_pow_o),
    .cluster_clk_en_o       (cluster_clk_en_o),
    .cluster_iso_o          (cluster_iso_o),
    .cluster_rstn_o         (cluster_rstn_o),
    .cluster_fetch_enable_o (cluster_fetch_enable_o),
    .cluster_byp_o          (cluster_byp_o),
    .busy_o                 (busy_o),
    .err_o                  (err_o),
    .evt_o                  (evt_o),
    .state_o                (state_o)
  );

  // pow / clk_en / iso / rstn for each state, straight from the rail table
  function automatic logic [3:0] rails(int s);
    case (s)
      S_PWR_UP:  return 4'b1010;
      S_CLK_EN:  return 4'b1110;
      S_ISO_REL: return 4'b1100;
      S_RST_REL: return 4'b1100;
      S_ON:      return 4'b1101;
      S_STOP:    return 4'b1100;
      S_ISO_SET: return 4'b1110;
      S_CLK_DIS: return 4'b1010;
      S_PWR_DN:  return 4'b0010;
      default:   return 4'b0010;
    endcase
  endfunction

  function automatic logic [12:0] observed();
    return {state_o, cluster_pow_o, cluster_clk_en_o, cluster_iso_o, cluster_rstn_o,
            cluster_fetch_enable_o, cluster_byp_o, busy_o, err_o, evt_o};
  endfunction

  task automatic check_vec(input string tag, input logic [12:0] got, input logic [12:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  // Advance n cycles expecting the sequencer to sit in state s; fetch/bypass requests are random noise
  task automatic go(input int s, input int n, input string tag);
    logic f_edge;
    logic b_edge;
    logic resting;
    logic [12:0] want;
    for (int i = 0; i < n; i++) begin
      f_edge = fetch_en_req_i;
      b_edge = byp_req_i;
      @(posedge HCLK);
      #1;
      if (prev_st == S_OFF) exp_byp = b_edge;
      resting = (s == S_OFF) || (s == S_ON) || (s == S_ERR);
      want = {4'(s), rails(s), (s == S_ON) && f_edge, exp_byp, !resting,
              s == S_ERR, resting && (s != prev_st)};
      check_vec($sformatf("%s[%0d]", tag, i), observed(), want);
      prev_st = s;
      fetch_en_req_i = 1'($urandom_range(0, 1));
      byp_req_i      = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    // Reset values while HRESET is held
    repeat (2) @(posedge HCLK);
    #1;
    check_vec("reset", observed(), {4'd0, 4'b0010, 1'b0, 1'b1, 3'b000});
    HRESET = 1'b0;
    go(S_OFF, 2, "idle");

    // Bypass follows the request while OFF
    go(S_OFF, 6, "byp_off");

    // Power-up with random pwr_ok delay; pow_req dropped in RST_REL
    d = $urandom_range(1, 40);
    pow_req_i = 1'b1;
    go(S_PWR_UP, d, "up1_wait");
    pwr_ok_i = 1'b1;
    go(S_PWR_UP, 2, "up1_sync");
    go(S_CLK_EN, 16, "up1_clk");
    go(S_ISO_REL, 1, "up1_iso");
    go(S_RST_REL, 3, "up1_rst_a");
    pow_req_i = 1'b0;
    go(S_RST_REL, 5, "up1_rst_b");
    go(S_ON, 1, "up1_on");
    go(S_STOP, 8, "dn1_stop");
    go(S_ISO_SET, 1, "dn1_iso");
    go(S_CLK_DIS, 1, "dn1_clk");
    go(S_PWR_DN, 1, "dn1_pwr");
    e = $urandom_range(0, 20);
    go(S_PWR_DN, e, "dn1_hold");
    pwr_ok_i = 1'b0;
    go(S_PWR_DN, 2, "dn1_sync");
    go(S_OFF, 2, "dn1_off");

    // Second cycle dwelling in ON with random fetch requests
    d = $urandom_range(1, 40);
    k = $urandom_range(3, 20);
    pow_req_i = 1'b1;
    go(S_PWR_UP, d, "up2_wait");
    pwr_ok_i = 1'b1;
    go(S_PWR_UP, 2, "up2_sync");
    go(S_CLK_EN, 16, "up2_clk");
    go(S_ISO_REL, 1, "up2_iso");
    go(S_RST_REL, 8, "up2_rst");
    go(S_ON, k, "up2_on");
    pow_req_i = 1'b0;
    go(S_STOP, 8, "dn2_stop");
    go(S_ISO_SET, 1, "dn2_iso");
    go(S_CLK_DIS, 1, "dn2_clk");
    pwr_ok_i = 1'b0;
    go(S_PWR_DN, 2, "dn2_pwr");
    go(S_OFF, 2, "dn2_off");

    // pwr_ok never arrives: timeout into ERROR, held until pow_req drops
    pow_req_i = 1'b1;
    go(S_PWR_UP, 1024, "to_wait");
    go(S_ERR, 3, "to_err");
    pow_req_i = 1'b0;
    go(S_OFF, 2, "to_off");

    // pok arrives exactly as the timeout expires: sequence continues
    pow_req_i = 1'b1;
    go(S_PWR_UP, 1022, "edge_wait");
    pwr_ok_i = 1'b1;
    go(S_PWR_UP, 2, "edge_sync");
    go(S_CLK_EN, 5, "edge_clk");

    // Asynchronous reset mid-sequence forces reset values before the next edge
    HRESET = 1'b1;
    #2;
    check_vec("reset_mid", observed(), {4'd0, 4'b0010, 1'b0, 1'b1, 3'b000});
    pow_req_i = 1'b0;
    pwr_ok_i  = 1'b0;
    @(posedge HCLK);
    #1;
    check_vec("reset_hold", observed(), {4'd0, 4'b0010, 1'b0, 1'b1, 3'b000});
    HRESET  = 1'b0;
    prev_st = S_OFF;
    exp_byp = 1'b1;
    go(S_OFF, 3, "post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
